// File: rtl/if_id_skid_register.sv
// IF/ID stage register: head flop drives decode, one skid entry behind it; optional perf counters (IF_ID_PERF_CNT_EN).
// Latency: 1 cycle push to OUT_VALID; sustains 1 instr/cycle while OUT_READY stays high.
// Backpressure: IN_READY comes only from registered state (low when FULL), so there is no OUT_READY->IN_READY comb path.
module if_id_skid_register #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h00000013)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [INSTR_WIDTH-1:0] INSTRUCTION,
    input  logic [ADDR_WIDTH-1:0]  PC,
    input  logic [ADDR_WIDTH-1:0]  PC_PLUS_4,
    input  logic                   FLUSH,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [INSTR_WIDTH-1:0] INSTRUCTION_OUT,
    output logic [ADDR_WIDTH-1:0]  PC_OUT,
    output logic [ADDR_WIDTH-1:0]  PC_PLUS_4_OUT,
    output logic [1:0]             OCCUPANCY
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]            STALL_CNT,
    output logic [31:0]            BUBBLE_CNT,
    output logic [31:0]            FLUSH_CNT
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic                   push;
    logic                   pop;
    logic                   head_from_in;
    logic                   head_from_skid;
    logic                   head_clear;
    logic                   skid_load;
    logic                   skid_clear;

    logic [INSTR_WIDTH-1:0] head_instr_q;
    logic [ADDR_WIDTH-1:0]  head_pc_q;
    logic [ADDR_WIDTH-1:0]  head_pc4_q;
    logic [INSTR_WIDTH-1:0] skid_instr_q;
    logic [ADDR_WIDTH-1:0]  skid_pc_q;
    logic [ADDR_WIDTH-1:0]  skid_pc4_q;
    logic [1:0]             occ_q;

    assign push = IN_VALID & IN_READY;
    assign pop  = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (FLUSH) begin
            state_nxt = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (push) state_nxt = ONE;
                ONE: begin
                    if (push && !pop)      state_nxt = FULL;
                    else if (!push && pop) state_nxt = EMPTY;
                end
                FULL:    if (pop) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Datapath controls; a flush wins over everything and scrubs both entries.
    always_comb begin
        IN_READY       = (state_q != FULL);
        OUT_VALID      = (state_q != EMPTY);
        head_from_in   = 1'b0;
        head_from_skid = 1'b0;
        head_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (FLUSH) begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: head_from_in = push;
                ONE: begin
                    head_from_in = push & pop;
                    skid_load    = push & !pop;
                    head_clear   = !push & pop;
                end
                FULL: begin
                    head_from_skid = pop;
                    skid_clear     = pop;
                end
                default: begin
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head_instr_q <= NOP_INSTR;
            head_pc_q    <= '0;
            head_pc4_q   <= '0;
        end else if (head_clear) begin
            head_instr_q <= NOP_INSTR;
            head_pc_q    <= '0;
            head_pc4_q   <= '0;
        end else if (head_from_in) begin
            head_instr_q <= INSTRUCTION;
            head_pc_q    <= PC;
            head_pc4_q   <= PC_PLUS_4;
        end else if (head_from_skid) begin
            head_instr_q <= skid_instr_q;
            head_pc_q    <= skid_pc_q;
            head_pc4_q   <= skid_pc4_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
        end else if (skid_clear) begin
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
        end else if (skid_load) begin
            skid_instr_q <= INSTRUCTION;
            skid_pc_q    <= PC;
            skid_pc4_q   <= PC_PLUS_4;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            occ_q <= 2'd0;
        end else begin
            case (state_nxt)
                ONE:     occ_q <= 2'd1;
                FULL:    occ_q <= 2'd2;
                default: occ_q <= 2'd0;
            endcase
        end
    end

    assign INSTRUCTION_OUT = head_instr_q;
    assign PC_OUT          = head_pc_q;
    assign PC_PLUS_4_OUT   = head_pc4_q;
    assign OCCUPANCY       = occ_q;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (OUT_VALID && !OUT_READY && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (!OUT_VALID && (bubble_cnt_q != 32'hFFFF_FFFF))
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (FLUSH && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign STALL_CNT  = stall_cnt_q;
    assign BUBBLE_CNT = bubble_cnt_q;
    assign FLUSH_CNT  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_register.sv
// Bench for if_id_skid_register: directed stimulus, queue scoreboard checked at every pop, plus directed status checks.
module tb_if_id_skid_register;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic [31:0] PC_PLUS_4;
    logic        FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] INSTRUCTION_OUT;
    logic [31:0] PC_OUT;
    logic [31:0] PC_PLUS_4_OUT;
    logic [1:0]  OCCUPANCY;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] STALL_CNT;
    logic [31:0] BUBBLE_CNT;
    logic [31:0] FLUSH_CNT;
`endif

    if_id_skid_register dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .IN_VALID        (IN_VALID),
        .IN_READY        (IN_READY),
        .INSTRUCTION     (INSTRUCTION),
        .PC              (PC),
        .PC_PLUS_4       (PC_PLUS_4),
        .FLUSH           (FLUSH),
        .OUT_VALID       (OUT_VALID),
        .OUT_READY       (OUT_READY),
        .INSTRUCTION_OUT (INSTRUCTION_OUT),
        .PC_OUT          (PC_OUT),
        .PC_PLUS_4_OUT   (PC_PLUS_4_OUT),
        .OCCUPANCY       (OCCUPANCY)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .STALL_CNT       (STALL_CNT),
        .BUBBLE_CNT      (BUBBLE_CNT),
        .FLUSH_CNT       (FLUSH_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA500_0000 | pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        IN_VALID    = v;
        PC          = pc;
        PC_PLUS_4   = pc + 32'd4;
        INSTRUCTION = instr_of(pc);
        OUT_READY   = ordy;
        FLUSH       = fl;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compares every pop against the scoreboard, checks bubble outputs, records accepted pushes.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                sb_q.delete();
            end else begin
                if (OUT_VALID && OUT_READY) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_pop_pc", PC_OUT, 32'hDEAD_BEEF);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_instr", INSTRUCTION_OUT, e.instr);
                        chk("sb_pc", PC_OUT, e.pc);
                        chk("sb_pc4", PC_PLUS_4_OUT, e.pc4);
                    end
                end
                if (!OUT_VALID) begin
                    chk("bubble_instr", INSTRUCTION_OUT, NOP);
                    chk("bubble_pc", PC_OUT, 32'd0);
                end
                if (FLUSH)
                    sb_q.delete();
                else if (IN_VALID && IN_READY)
                    sb_q.push_back('{instr: INSTRUCTION, pc: PC, pc4: PC_PLUS_4});
            end
        end
    end

    initial begin
        RESET = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_instr", INSTRUCTION_OUT, NOP);
        chk("rst_pc", PC_OUT, 32'd0);
        chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
        chk("rst_occ", {30'd0, OCCUPANCY}, 32'd0);
        tick();
        RESET = 1'b0;

        // Streaming with decode always ready
        drive(1'b1, 32'h00, 1'b1, 1'b0); tick();
        chk("str0_pc", PC_OUT, 32'h00);
        chk("str0_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("str0_occ", {30'd0, OCCUPANCY}, 32'd1);
        drive(1'b1, 32'h04, 1'b1, 1'b0); tick();
        chk("str1_pc", PC_OUT, 32'h04);
        chk("str1_occ", {30'd0, OCCUPANCY}, 32'd1);
        chk("str1_in_ready", {31'd0, IN_READY}, 32'd1);
        drive(1'b1, 32'h08, 1'b1, 1'b0); tick();
        chk("str2_pc", PC_OUT, 32'h08);
        chk("str2_pc4", PC_PLUS_4_OUT, 32'h0C);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        chk("str_drain_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("str_drain_occ", {30'd0, OCCUPANCY}, 32'd0);

        // Backpressure fills the skid entry
        drive(1'b1, 32'h10, 1'b0, 1'b0); tick();
        chk("bp0_pc", PC_OUT, 32'h10);
        drive(1'b1, 32'h14, 1'b0, 1'b0); tick();
        chk("bp1_occ", {30'd0, OCCUPANCY}, 32'd2);
        chk("bp1_in_ready", {31'd0, IN_READY}, 32'd0);
        chk("bp1_pc_hold", PC_OUT, 32'h10);
        drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
        chk("bp2_pc_hold", PC_OUT, 32'h10);
        chk("bp2_instr_hold", INSTRUCTION_OUT, instr_of(32'h10));
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        chk("bp3_pc", PC_OUT, 32'h14);
        chk("bp3_occ", {30'd0, OCCUPANCY}, 32'd1);
        chk("bp3_in_ready", {31'd0, IN_READY}, 32'd1);
        tick();
        chk("bp4_valid", {31'd0, OUT_VALID}, 32'd0);

        // Flush while FULL with a simultaneous incoming 0x20
        drive(1'b1, 32'h18, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h1C, 1'b0, 1'b0); tick();
        chk("fl_full_occ", {30'd0, OCCUPANCY}, 32'd2);
        drive(1'b1, 32'h20, 1'b0, 1'b1); tick();
        chk("fl_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("fl_occ", {30'd0, OCCUPANCY}, 32'd0);
        chk("fl_in_ready", {31'd0, IN_READY}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        chk("fl_after_valid", {31'd0, OUT_VALID}, 32'd0);

        // Flush in ONE with pop and push in the same cycle: pop consumed, push dropped
        drive(1'b1, 32'h24, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h28, 1'b1, 1'b1); tick();
        chk("fl1_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("fl1_occ", {30'd0, OCCUPANCY}, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();

        // Simultaneous push and pop in ONE
        drive(1'b1, 32'h30, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h34, 1'b1, 1'b0); tick();
        chk("pp_pc", PC_OUT, 32'h34);
        chk("pp_occ", {30'd0, OCCUPANCY}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();

        // Asynchronous reset mid-cycle while FULL
        drive(1'b1, 32'h40, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h44, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2 RESET = 1'b1;
        #1;
        chk("arst_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("arst_in_ready", {31'd0, IN_READY}, 32'd1);
        chk("arst_occ", {30'd0, OCCUPANCY}, 32'd0);
        chk("arst_instr", INSTRUCTION_OUT, NOP);
        chk("arst_pc4", PC_PLUS_4_OUT, 32'd0);
        tick();
        RESET = 1'b0;

`ifdef IF_ID_PERF_CNT_EN
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick(); tick(); tick();
        drive(1'b1, 32'h50, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1); tick();
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        chk("perf_stall", STALL_CNT, 32'd5);
        chk("perf_flush", FLUSH_CNT, 32'd2);
        chk("perf_bubble_ge3", {31'd0, (BUBBLE_CNT >= 32'd3)}, 32'd1);
        @(negedge CLK);
        force dut.bubble_cnt_q = 32'hFFFF_FFFD;
        #1 release dut.bubble_cnt_q;
        tick(); tick(); tick();
        chk("perf_bubble_sat", BUBBLE_CNT, 32'hFFFF_FFFF);
        tick();
        chk("perf_bubble_hold", BUBBLE_CNT, 32'hFFFF_FFFF);
`endif

        tick();
        chk("sb_leftover", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/if_id_skid_register.md
Name: if_id_skid_register

Overview:
Parametrised IF/ID pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Decouples fetch from decode so that a decode stall does not create a combinational ready path back into fetch.
- Supports synchronous flush on branch or jump redirect.
- Presents a NOP bubble whenever no valid instruction is held.
- Sits between the fetch unit and the decode stage of the RV32IM pipeline.

Parameters:
- INSTR_WIDTH, 32, width of INSTRUCTION / INSTRUCTION_OUT
- ADDR_WIDTH, 32, width of PC / PC_PLUS_4 and their outputs
- NOP_INSTR, 32'h00000013, encoding driven on INSTRUCTION_OUT when OUT_VALID=0 (addi x0,x0,0); width INSTR_WIDTH

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- IN_VALID  in  1  fetch presents a valid instruction
- IN_READY  out  1  stage can accept; equals 1 when state != FULL
- INSTRUCTION  in  INSTR_WIDTH  fetched instruction
- PC  in  ADDR_WIDTH  instruction address
- PC_PLUS_4  in  ADDR_WIDTH  sequential next address
- FLUSH  in  1  discard all held and incoming entries
- OUT_VALID  out  1  head entry valid for decode
- OUT_READY  in  1  decode consumes head this cycle
- INSTRUCTION_OUT  out  INSTR_WIDTH  head instruction, or NOP_INSTR
- PC_OUT  out  ADDR_WIDTH  head PC, or 0 when invalid
- PC_PLUS_4_OUT  out  ADDR_WIDTH  head PC+4, or 0 when invalid
- OCCUPANCY  out  2  number of held entries (0..2)
- STALL_CNT  out  32  present only with IF_ID_PERF_CNT_EN
- BUBBLE_CNT  out  32  present only with IF_ID_PERF_CNT_EN
- FLUSH_CNT  out  32  present only with IF_ID_PERF_CNT_EN

Behaviour:
- Clocking and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values:
  - state=EMPTY, OUT_VALID=0, IN_READY=1, OCCUPANCY=0
  - INSTRUCTION_OUT=NOP_INSTR, PC_OUT=0, PC_PLUS_4_OUT=0
  - skid entry cleared
- Storage: a head register drives the outputs directly from flops; a skid register sits behind it. OCCUPANCY is registered.
- Handshake events:
  - push = IN_VALID & IN_READY
  - pop = OUT_VALID & OUT_READY
  - Inputs are sampled only on push.
  - Outputs hold stable while OUT_VALID=1 and OUT_READY=0.
- State machine transitions (FLUSH=0):
  - EMPTY: push -> ONE (head<=input). No push -> EMPTY. pop is impossible.
  - ONE, push & pop: head<=input, stay ONE.
  - ONE, push & !pop: skid<=input, go FULL.
  - ONE, !push & pop: go EMPTY; outputs revert to NOP/0.
  - ONE, neither: hold.
  - FULL: IN_READY=0, so push is impossible. pop -> head<=skid, go ONE. Otherwise hold.
- Latency: 1 cycle from push to OUT_VALID when EMPTY. Throughput is 1 instruction/cycle when OUT_READY stays high.
- Ordering: strict FIFO; no entry is ever duplicated or dropped except by FLUSH.
- FLUSH (synchronous, highest priority):
  - next state=EMPTY; outputs become NOP/0 next cycle.
  - Any push in the flush cycle is discarded.
  - A pop in the flush cycle still counts as consumed by decode.
  - IN_READY=1 in the cycle after the flush.
- RESET asserted mid-operation clears state immediately, independent of CLK; held entries are lost.
- IN_READY depends only on registered state; there is no combinational path from OUT_READY to IN_READY.

Optional Feature:
Macro IF_ID_PERF_CNT_EN.
- When defined, three 32-bit saturating counters are added, each reset to 0 by RESET:
  - STALL_CNT increments on cycles with OUT_VALID & !OUT_READY.
  - BUBBLE_CNT increments on cycles with !OUT_VALID.
  - FLUSH_CNT increments on each cycle with FLUSH=1.
- Each counter holds at 32'hFFFFFFFF.
- When not defined, the three ports and all counter logic are absent, and the rest of the behaviour is identical.

Test Plan:
- Reset then idle: RESET=1 mid-cycle -> OUT_VALID=0, INSTRUCTION_OUT=32'h00000013, PC_OUT=0, IN_READY=1 immediately, before any CLK edge.
- Streaming with OUT_READY=1: push PC=0x00,0x04,0x08 on consecutive cycles -> PC_OUT 0x00,0x04,0x08 one cycle later each, OCCUPANCY stays 1, IN_READY stays 1.
- Backpressure: OUT_READY=0, push PC=0x10 then 0x14 -> OCCUPANCY=2, IN_READY=0, PC_OUT holds 0x10. Raise OUT_READY -> PC_OUT 0x10, then 0x14, then OUT_VALID=0.
- Flush while FULL, with simultaneous IN_VALID carrying PC=0x20 -> next cycle OUT_VALID=0, OCCUPANCY=0, IN_READY=1, PC=0x20 never appears at the output.
- Simultaneous push and pop in ONE: head PC=0x30, push 0x34 with OUT_READY=1 -> next cycle PC_OUT=0x34, OCCUPANCY=1.
- With IF_ID_PERF_CNT_EN: 5 stall cycles, 2 flushes, and 3 empty cycles after reset -> STALL_CNT=5, FLUSH_CNT=2, BUBBLE_CNT>=3. With BUBBLE_CNT preset near 32'hFFFFFFFF via long idle (or a force), it saturates.
